adc_conv_arbiter: RTL and testbench
===================================

Name: adc_conv_arbiter

Overview:
Shares the single on-chip monitoring ADC between N_REQ conversion requesters.
- Round-robin arbitration picks a requester and drives the ADC input-mux channel.
- It waits a mux settle time, then issues the start-of-conversion pulse.
- It waits for end-of-conversion, captures the 12-bit result and returns it to the owning requester.
- Sits between the ADC clock/SOC generator and the monitoring/register-readout logic.

Parameters:
N_REQ, 4, number of requesters (2..8)
CH_W, 6, mux channel select width
DATA_W, 12, ADC result width
SETTLE_CYC, 16, CLOCK cycles of mux settling before SOC (>=1)
SOC_CYC, 4, SOC high duration in CLOCK cycles (>=1)
TIMEOUT_CYC, 4096, maximum CLOCK cycles waiting for EOC

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESETB  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester conversion request, held until granted
req_ch  in  N_REQ*CH_W  per-requester channel; slice i belongs to requester i
req_grant  out  N_REQ  one-cycle one-hot grant pulse; the request is consumed
rsp_valid  out  N_REQ  one-cycle one-hot result pulse to the owner
rsp_data  out  DATA_W  result, valid while any rsp_valid bit is high
rsp_err  out  1  timeout flag, qualified by rsp_valid
adc_mux_sel  out  CH_W  ADC input mux select
adc_soc  out  1  start-of-conversion to the ADC
adc_eoc  in  1  end-of-conversion from the ADC, asynchronous
adc_data  in  DATA_W  ADC result, stable while adc_eoc is high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, RESETB low): state IDLE.
  - All outputs 0.
  - Round-robin pointer = 0; counters = 0; EOC synchronizer = 0.
  - Reset mid-conversion drops adc_soc immediately and produces no rsp_valid.
- EOC conditioning: 2-flop synchronizer, then rising-edge detect (eoc_rise).
  - eoc_rise outside WAIT_EOC is ignored.
  - adc_eoc already high when WAIT_EOC is entered does not count; only a fresh rising edge does.
- States: IDLE, SETTLE, SOC, WAIT_EOC, CAPTURE.
- IDLE, any req_valid:
  - Winner = first set bit at or after the pointer, wrapping modulo N_REQ.
  - req_grant[winner] pulses for exactly this cycle.
  - The winner's req_ch is latched into adc_mux_sel.
  - The owner index is latched.
  - Pointer = (winner+1) mod N_REQ.
  - Next state SETTLE.
  - No request: stay in IDLE; adc_mux_sel holds its last value.
- SETTLE: counts SETTLE_CYC cycles, then goes to SOC.
- SOC: adc_soc = 1 for exactly SOC_CYC cycles, then goes to WAIT_EOC. adc_soc is registered and glitch-free.
- WAIT_EOC:
  - eoc_rise: capture adc_data (the sample on the eoc_rise cycle), rsp_err = 0, go to CAPTURE.
  - TIMEOUT_CYC cycles elapse without eoc_rise: data = all ones (0xFFF), rsp_err = 1, go to CAPTURE.
  - eoc_rise on the same cycle as timeout expiry: eoc_rise wins.
- CAPTURE: rsp_valid[owner] = 1 for one cycle with rsp_data and rsp_err; next state IDLE.
- rsp_data and rsp_err hold their values until the next CAPTURE.
- Latency:
  - Grant to first adc_soc high = SETTLE_CYC+1 cycles.
  - adc_eoc pin rise to rsp_valid = 3 cycles.
- Requests arriving while busy wait; req_valid dropped before grant is legal and is simply not served.
- Grant back-to-back: the earliest next grant is the cycle after CAPTURE.
- Counters are sized $clog2(max+1) and saturate, never wrap.

Optional Feature:
ADC_AVG_EN
- Defined:
  - Each grant performs 4 consecutive SOC/WAIT_EOC cycles on the same channel; SETTLE runs only before the first.
  - The 4 results are accumulated in DATA_W+2 bits; rsp_data = sum>>2, truncated.
  - Any timeout aborts the remaining conversions and returns 0xFFF with rsp_err = 1.
- Undefined: a single conversion per grant, exactly as above.

Decomposition:
- Package adc_ctrl_pkg:
  - State enum (IDLE, SETTLE, SOC, WAIT_EOC, CAPTURE).
  - ADC_ERR_VALUE = all ones.
  - AVG_SHIFT = 2; AVG_COUNT = 4.
  - Counter-width helper function.
- Sub-module adc_rr_arb:
  - Combinational winner select from req_valid and the pointer.
  - The pointer register lives in adc_rr_arb, updated on grant.

Test Plan:
- Reset, req_valid=0001, ch0=6'h15, ADC model EOC 40 cycles after SOC with data 12'hA5C -> req_grant=0001 one cycle; adc_mux_sel=6'h15; SOC high 4 cycles starting 17 cycles after grant; rsp_valid=0001 3 cycles after EOC; rsp_data=A5C; rsp_err=0.
- req_valid=1111 held continuously -> grants in order 0,1,2,3,0; each requester gets rsp_valid only on its own bit.
- ADC model never raises EOC -> rsp_valid after 4096 WAIT_EOC cycles; rsp_data=FFF; rsp_err=1; next request is served normally.
- adc_eoc stuck high from the previous conversion, or pulsing during SETTLE -> ignored; only a fresh rise in WAIT_EOC produces the result.
- RESETB low during SOC -> adc_soc=0 and busy=0 immediately, no rsp_valid; after release, req_valid=0100 gives req_grant=0100 (pointer reset to 0).
- ADC_AVG_EN defined, samples 100,101,102,105 -> exactly 4 SOC pulses; rsp_data=102 (408>>2).

Source files
------------

// File: rtl/adc_conv_arbiter_pkg.sv
// adc_ctrl_pkg: shared types and constants for the ADC conversion arbiter.
// Provides the FSM state enum, error/averaging constants, counter sizing.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SOC,
        WAIT_EOC,
        CAPTURE
    } state_t;

    localparam logic [31:0] ADC_ERR_VALUE = '1;
    localparam int AVG_SHIFT = 2;
    localparam int AVG_COUNT = 4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_conv_arbiter_if.sv
// Requester-side bundle of the ADC conversion arbiter.
// master: requester/readout side; slave: the arbiter.
interface adc_conv_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int CH_W   = 6,
    parameter int DATA_W = 12
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*CH_W-1:0] req_ch;
    logic [N_REQ-1:0]      req_grant;
    logic [N_REQ-1:0]      rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_ch,
        input  req_grant, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_ch,
        output req_grant, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/adc_conv_arbiter_rr_arb.sv
// adc_rr_arb: round-robin winner select with its own pointer register.
// Ports: CLOCK, RESETB, req_valid, grant_en in; any, win, grant out.
module adc_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             CLOCK,
    input  logic             RESETB,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             grant_en,
    output logic             any,
    output logic [IDX_W-1:0] win,
    output logic [N_REQ-1:0] grant
);
    logic [IDX_W-1:0] ptr_q;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        int idx;
        any = 1'b0;
        win = '0;
        idx = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[IDX_W'(idx)]) begin
                any = 1'b1;
                win = IDX_W'(idx);
            end
        end
    end

    assign grant = (grant_en && any) ? (N_REQ'(1) << win) : '0;

    always_ff @(posedge CLOCK or negedge RESETB) begin
        if (!RESETB) begin
            ptr_q <= '0;
        end else if (grant_en && any) begin
            ptr_q <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: rtl/adc_conv_arbiter.sv
// adc_conv_arbiter: shares one ADC between N_REQ requesters (round-robin).
// Ports: CLOCK, RESETB; bus (req/grant/rsp); adc_mux_sel, adc_soc, adc_eoc,
// adc_data; busy. Optional ADC_AVG_EN: average 4 conversions per grant.
module adc_conv_arbiter
    import adc_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CH_W        = 6,
    parameter int DATA_W      = 12,
    parameter int SETTLE_CYC  = 16,
    parameter int SOC_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              CLOCK,
    input  logic              RESETB,
    adc_conv_arbiter_if.slave bus,
    output logic [CH_W-1:0]   adc_mux_sel,
    output logic              adc_soc,
    input  logic              adc_eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              busy
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int MAX_A   = (SETTLE_CYC > SOC_CYC) ? SETTLE_CYC : SOC_CYC;
    localparam int CNT_MAX = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SOC_LAST    = CNT_W'(SOC_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  win;
    logic              any;
    logic              grant_en;
    logic [N_REQ-1:0]  owner_oh;
    logic [2:0]        eoc_sync;
    logic              eoc_rise;
    logic [N_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

`ifdef ADC_AVG_EN
    localparam int CONV_W = $clog2(AVG_COUNT);
    logic [CONV_W-1:0] conv_q;
    logic [DATA_W+1:0] acc_q;
    logic [DATA_W+1:0] acc_nxt;
    logic              last_conv;

    assign acc_nxt   = acc_q + {2'b00, adc_data};
    assign last_conv = (conv_q == CONV_W'(AVG_COUNT - 1));
`endif

    assign grant_en = (state_q == IDLE);
    assign owner_oh = N_REQ'(1) << owner_q;
    // Saturate rather than wrap.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    // Edge detect after the 2-flop synchronizer; a held-high pin never fires.
    assign eoc_rise = eoc_sync[1] & ~eoc_sync[2];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    adc_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .CLOCK     (CLOCK),
        .RESETB    (RESETB),
        .req_valid (bus.req_valid),
        .grant_en  (grant_en),
        .any       (any),
        .win       (win),
        .grant     (bus.req_grant)
    );

    always_ff @(posedge CLOCK or negedge RESETB) begin
        if (!RESETB) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= '0;
            adc_mux_sel <= '0;
            adc_soc     <= 1'b0;
            busy        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            eoc_sync    <= '0;
`ifdef ADC_AVG_EN
            conv_q      <= '0;
            acc_q       <= '0;
`endif
        end else begin
            eoc_sync <= {eoc_sync[1:0], adc_eoc};
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        owner_q     <= win;
                        adc_mux_sel <= bus.req_ch[win*CH_W +: CH_W];
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        state_q     <= SETTLE;
`ifdef ADC_AVG_EN
                        conv_q      <= '0;
                        acc_q       <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        adc_soc <= 1'b1;
                        state_q <= SOC;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                SOC: begin
                    if (cnt_q == SOC_LAST) begin
                        cnt_q   <= '0;
                        adc_soc <= 1'b0;
                        state_q <= WAIT_EOC;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                WAIT_EOC: begin
                    // A rise on the expiry cycle still counts as a result.
                    if (eoc_rise) begin
`ifdef ADC_AVG_EN
                        if (last_conv) begin
                            rsp_data_q  <= DATA_W'(acc_nxt >> AVG_SHIFT);
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= owner_oh;
                            state_q     <= CAPTURE;
                        end else begin
                            acc_q   <= acc_nxt;
                            conv_q  <= conv_q + 1'b1;
                            cnt_q   <= '0;
                            adc_soc <= 1'b1;
                            state_q <= SOC;
                        end
`else
                        rsp_data_q  <= adc_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= owner_oh;
                        state_q     <= CAPTURE;
`endif
                    end else if (cnt_q == TMO_LAST) begin
                        rsp_data_q  <= ADC_ERR_VALUE[DATA_W-1:0];
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= owner_oh;
                        state_q     <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                CAPTURE: begin
                    rsp_valid_q <= '0;
                    busy        <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Self-checking bench for adc_conv_arbiter with an ADC model and a
// response scoreboard; all stimulus, model and checks run in one process.
module tb_adc_conv_arbiter;
    localparam int N  = 4;
    localparam int CW = 6;
    localparam int DW = 12;

    typedef struct {
        int          owner;
        logic [DW-1:0] data;
        logic        err;
    } exp_t;

    logic          CLOCK = 1'b0;
    logic          RESETB = 1'b0;
    logic [CW-1:0] adc_mux_sel;
    logic          adc_soc;
    logic          adc_eoc;
    logic [DW-1:0] adc_data;
    logic          busy;

    adc_conv_arbiter_if #(.N_REQ(N), .CH_W(CW), .DATA_W(DW)) bus ();

    adc_conv_arbiter #(
        .N_REQ(N), .CH_W(CW), .DATA_W(DW),
        .SETTLE_CYC(16), .SOC_CYC(4), .TIMEOUT_CYC(4096)
    ) dut (
        .CLOCK       (CLOCK),
        .RESETB      (RESETB),
        .bus         (bus),
        .adc_mux_sel (adc_mux_sel),
        .adc_soc     (adc_soc),
        .adc_eoc     (adc_eoc),
        .adc_data    (adc_data),
        .busy        (busy)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;
    exp_t sb_q[$];
    logic [DW-1:0] samp_q[$];
    logic [CW-1:0] ch_tab [N] = '{6'h15, 6'h11, 6'h12, 6'h13};

    int model_delay = 40;
    logic [DW-1:0] model_data = '0;
    logic stuck = 1'b0;
    int soc_pulses = 0;
    int cd = -1;
    int hold = 0;
    logic soc_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC model: EOC pulse model_delay cycles after each SOC rise.
    task automatic model_step();
        if (!RESETB) begin
            cd = -1;
            soc_prev = 1'b0;
        end else begin
            if (adc_soc && !soc_prev) begin
                soc_pulses++;
                if (model_delay > 0) cd = model_delay;
            end
            soc_prev = adc_soc;
            if (hold > 0) begin
                hold--;
                if (hold == 0 && !stuck) adc_eoc = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (samp_q.size() > 0) adc_data = samp_q.pop_front();
                    else adc_data = model_data;
                    adc_eoc = 1'b1;
                    hold = 2;
                    cd = -1;
                end
            end
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (|bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_owner", 32'(bus.rsp_valid), 32'd1 << e.owner);
                chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    endtask

    task automatic hp();
        @(posedge CLOCK);
        #1;
        model_step();
    endtask

    task automatic hn();
        @(negedge CLOCK);
        mon_step();
    endtask

    task automatic cyc();
        hp();
        hn();
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && sb_q.size() > 0; i++) cyc();
        chk("rsp_wait", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_req(input logic [N-1:0] mask, input int owner,
                          input logic [DW-1:0] d, input logic e);
        hp();
        bus.req_valid = mask;
        hn();
        chk("grant", 32'(bus.req_grant), 32'd1 << owner);
        sb_q.push_back('{owner, d, e});
        hp();
        bus.req_valid = '0;
        hn();
        chk("grant_drop", 32'(bus.req_grant), 32'd0);
        chk("mux_sel", 32'(adc_mux_sel), 32'(ch_tab[owner]));
        chk("busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_soc_rise();
        int k;
        k = 0;
        while (!adc_soc && k < 100) begin
            cyc();
            k++;
        end
        chk("soc_seen", 32'(adc_soc), 32'd1);
    endtask

    initial begin
        int k;
        int w;
        int s0;
        bus.req_valid = '0;
        bus.req_ch = {ch_tab[3], ch_tab[2], ch_tab[1], ch_tab[0]};
        adc_eoc = 1'b0;
        adc_data = '0;

        repeat (3) cyc();
        chk("rst_grant", 32'(bus.req_grant), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mux", 32'(adc_mux_sel), 32'd0);
        chk("rst_soc", 32'(adc_soc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        RESETB = 1'b1;
        cyc();

        // Single conversion, latency checks.
        model_delay = 40;
        model_data = 12'hA5C;
        do_req(4'b0001, 0, 12'hA5C, 1'b0);
        k = 1;
        while (!adc_soc && k < 100) begin
            cyc();
            k++;
        end
        chk("soc_start", 32'(k), 32'd17);
        k = 0;
        while (adc_soc && k < 20) begin
            cyc();
            k++;
        end
        chk("soc_len", 32'(k), 32'd4);
`ifndef ADC_AVG_EN
        k = 0;
        while (!adc_eoc && k < 200) begin
            cyc();
            k++;
        end
        k = 0;
        while (!(|bus.rsp_valid) && k < 10) begin
            cyc();
            k++;
        end
        chk("eoc_to_rsp", 32'(k), 32'd3);
`endif
        wait_done(1000);
        repeat (3) cyc();
        chk("rsp_hold_data", 32'(bus.rsp_data), 32'h0A5C);
        chk("idle_busy", 32'(busy), 32'd0);

        // Round robin with all requests held, from a fresh pointer.
        RESETB = 1'b0;
        cyc();
        RESETB = 1'b1;
        cyc();
        hp();
        bus.req_valid = 4'b1111;
        hn();
        for (int r = 0; r < 5; r++) begin
            int j;
            int idx;
            idx = r % 4;
            j = 0;
            while (!(|bus.req_grant) && j < 1000) begin
                cyc();
                j++;
            end
            chk("rr_grant", 32'(bus.req_grant), 32'd1 << idx);
            model_data = 12'h100 + 12'(r);
            sb_q.push_back('{idx, model_data, 1'b0});
            hp();
            if (r == 4) bus.req_valid = '0;
            hn();
            chk("rr_mux", 32'(adc_mux_sel), 32'(ch_tab[idx]));
        end
        wait_done(1000);

        // EOC never arrives: timeout then a normal conversion.
        model_delay = 0;
        do_req(4'b0010, 1, 12'hFFF, 1'b1);
        wait_soc_rise();
        k = 0;
        while (adc_soc && k < 100) begin
            cyc();
            k++;
        end
        w = 0;
        while (!(|bus.rsp_valid) && w < 5000) begin
            w++;
            cyc();
        end
        chk("timeout_len", 32'(w), 32'd4096);
        wait_done(10);
        model_delay = 40;
        model_data = 12'h7E7;
        do_req(4'b0100, 2, 12'h7E7, 1'b0);
        wait_done(1000);

        // EOC pulse during SETTLE is ignored.
        model_data = 12'h222;
        do_req(4'b1000, 3, 12'h222, 1'b0);
        repeat (2) cyc();
        hp();
        adc_data = 12'h111;
        adc_eoc = 1'b1;
        hn();
        cyc();
        hp();
        adc_eoc = 1'b0;
        hn();
        wait_done(1000);

`ifndef ADC_AVG_EN
        // EOC left high: only a fresh rise in WAIT_EOC counts.
        stuck = 1'b1;
        model_data = 12'h456;
        do_req(4'b0001, 0, 12'h456, 1'b0);
        wait_done(1000);
        model_delay = 0;
        do_req(4'b0010, 1, 12'h3C3, 1'b0);
        wait_soc_rise();
        repeat (30) cyc();
        chk("stuck_no_rsp", 32'(sb_q.size()), 32'd1);
        hp();
        adc_eoc = 1'b0;
        hn();
        cyc();
        hp();
        adc_data = 12'h3C3;
        adc_eoc = 1'b1;
        hn();
        wait_done(100);
        hp();
        adc_eoc = 1'b0;
        stuck = 1'b0;
        hn();
`endif

        // Reset during SOC, then pointer restarts at 0.
        model_delay = 0;
        do_req(4'b0100, 2, 12'h000, 1'b0);
        wait_soc_rise();
        cyc();
        hp();
        #2;
        RESETB = 1'b0;
        #1;
        chk("rst_mid_soc", 32'(adc_soc), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_mux", 32'(adc_mux_sel), 32'd0);
        sb_q.delete();
        hn();
        repeat (2) cyc();
        RESETB = 1'b1;
        cyc();
        model_delay = 40;
        model_data = 12'h5A5;
        do_req(4'b1100, 2, 12'h5A5, 1'b0);
        wait_done(1000);

`ifdef ADC_AVG_EN
        samp_q.push_back(12'd100);
        samp_q.push_back(12'd101);
        samp_q.push_back(12'd102);
        samp_q.push_back(12'd105);
        s0 = soc_pulses;
        do_req(4'b0001, 0, 12'd102, 1'b0);
        wait_done(2000);
        chk("avg_soc_pulses", 32'(soc_pulses - s0), 32'd4);
`else
        s0 = 0;
`endif

        repeat (5) cyc();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
